// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO result registers
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mul_div_unit #(
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [WORD_WIDTH-1:0] inA,
    input  logic [WORD_WIDTH-1:0] inB,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] hi,
    output logic [WORD_WIDTH-1:0] lo,
    output logic                  div_zero
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    cnt;

    // Iteration registers: for multiply acc/qr are the upper/lower product
    // halves, for divide they are the partial remainder and the quotient.
    logic [WORD_WIDTH-1:0]   acc;
    logic [WORD_WIDTH-1:0]   qr;
    // Operand that is added (multiply) or subtracted (divide) every step.
    logic [WORD_WIDTH-1:0]   opd;
    logic [WORD_WIDTH-1:0]   a_raw;
    logic                    is_div;
    logic                    neg_q;
    logic                    neg_r;
    logic                    dz;

    // Operand conditioning at acceptance: signed ops work on magnitudes.
    logic                    in_signed;
    logic                    a_neg;
    logic                    b_neg;
    logic [WORD_WIDTH-1:0]   mag_a;
    logic [WORD_WIDTH-1:0]   mag_b;

    // One radix-2 step for each operation, plus the sign-corrected final result.
    logic [WORD_WIDTH:0]     mul_sum;
    logic [WORD_WIDTH:0]     div_shift;
    logic                    div_ge;
    logic [WORD_WIDTH-1:0]   acc_nx;
    logic [WORD_WIDTH-1:0]   qr_nx;
    logic [2*WORD_WIDTH-1:0] prod;
    logic [2*WORD_WIDTH-1:0] prod_fix;
    logic [WORD_WIDTH-1:0]   res_hi;
    logic [WORD_WIDTH-1:0]   res_lo;

    // Magnitudes and sign flags for the operands presented with start
    always_comb begin
        in_signed = ~op[0];
        a_neg     = in_signed & inA[WORD_WIDTH-1];
        b_neg     = in_signed & inB[WORD_WIDTH-1];
        mag_a     = a_neg ? (WORD_WIDTH'(0) - inA) : inA;
        mag_b     = b_neg ? (WORD_WIDTH'(0) - inB) : inB;
    end

    // Single iteration step and the result that is committed on the last step
    always_comb begin
        mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, opd} : {(WORD_WIDTH+1){1'b0}});
        div_shift = {acc, qr[WORD_WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opd});
        if (is_div) begin
            acc_nx = div_ge ? (div_shift[WORD_WIDTH-1:0] - opd) : div_shift[WORD_WIDTH-1:0];
            qr_nx  = {qr[WORD_WIDTH-2:0], div_ge};
        end else begin
            acc_nx = mul_sum[WORD_WIDTH:1];
            qr_nx  = {mul_sum[0], qr[WORD_WIDTH-1:1]};
        end
        prod     = {acc_nx, qr_nx};
        prod_fix = neg_q ? ((2*WORD_WIDTH)'(0) - prod) : prod;
        if (!is_div) begin
            res_hi = prod_fix[2*WORD_WIDTH-1:WORD_WIDTH];
            res_lo = prod_fix[WORD_WIDTH-1:0];
        end else if (dz) begin
            // Divide by zero: quotient saturates, remainder keeps the dividend.
            res_hi = a_raw;
            res_lo = {WORD_WIDTH{1'b1}};
        end else begin
            // Most-negative / -1 falls out naturally: 2^(W-1) negated wraps to itself.
            res_hi = neg_r ? (WORD_WIDTH'(0) - acc_nx) : acc_nx;
            res_lo = neg_q ? (WORD_WIDTH'(0) - qr_nx) : qr_nx;
        end
    end

    // Control FSM, iteration registers and the registered HI/LO/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            qr       <= '0;
            opd      <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (op == OP_MTHI) begin
                            hi       <= inA;
                            div_zero <= 1'b0;
                        end else if (op == OP_MTLO) begin
                            lo       <= inA;
                            div_zero <= 1'b0;
                        end else if (!op[2]) begin
                            is_div   <= op[1];
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            dz       <= op[1] & (inB == '0);
                            a_raw    <= inA;
                            opd      <= op[1] ? mag_b : mag_a;
                            qr       <= op[1] ? mag_a : mag_b;
                            acc      <= '0;
                            cnt      <= '0;
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= acc_nx;
                        qr  <= qr_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            hi       <= res_hi;
                            lo       <= res_lo;
                            div_zero <= dz;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit against a behavioural model
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_seen = 0;
    int pushed = 0;

    logic [64:0]  exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .inA(inA), .inB(inB),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain wide arithmetic, {div_zero, hi, lo}
    function automatic logic [64:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p, q64, r64;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin p = sa * sb; return {1'b0, p}; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            3'd2: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb; sr = sa % sb; q64 = sq; r64 = sr;
                return {1'b0, r64[31:0], q64[31:0]};
            end
            3'd3: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: return {m_dz, m_hi, m_lo};
        endcase
    endfunction

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got hi=%h lo=%h with no result pending", hi, lo);
            end else begin
                e = exp_q.pop_front();
                chk("result", {div_zero, hi, lo}, e);
            end
        end
    end

    // Issue one operation; called and returns at a falling edge.
    // flush_at = edge index (1..33) at which flush is sampled, 0 for none.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int flush_at, input bit poke);
        int          cyc;
        int          done_at;
        int          exp_cyc;
        bit          kept;
        logic [64:0] e;
        start = 1'b1; op = o; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0;
        if (o[2]) begin
            if (o == 3'd4) begin m_hi = a; m_dz = 1'b0; end
            if (o == 3'd5) begin m_lo = a; m_dz = 1'b0; end
            chk("direct_op_regs", {div_zero, hi, lo}, {m_dz, m_hi, m_lo});
            chk("direct_op_busy", {64'b0, busy}, 65'd0);
            return;
        end
        e = model(o, a, b);
        kept = (flush_at == 0) || (flush_at >= 33);
        if (kept) begin
            exp_q.push_back(e);
            pushed++;
        end
        exp_cyc = kept ? 33 : flush_at;
        cyc = 0;
        done_at = -1;
        while (busy && cyc < 40) begin
            cyc++;
            inA = $urandom; inB = $urandom; op = 3'($urandom_range(0, 7));
            start = poke && (cyc == 5 || cyc == 20);
            if (start) op = 3'd4;
            flush = (cyc == flush_at);
            @(negedge clk);
            if (done) done_at = cyc;
        end
        start = 1'b0;
        flush = 1'b0;
        if (kept) begin
            m_dz = e[64]; m_hi = e[63:32]; m_lo = e[31:0];
            chk("done_edge", 65'(done_at), 65'd32);
        end
        chk("busy_cycles", 65'(cyc), 65'(exp_cyc));
        chk("regs_after", {div_zero, hi, lo}, {m_dz, m_hi, m_lo});
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int fa;
        logic [2:0] ro;

        repeat (2) @(negedge clk);
        chk("reset_state", {30'b0, busy, done, div_zero, hi, lo}, 65'd0);
        rst_n = 1'b1;

        // Accepted on the very first edge after reset release
        do_op(3'd5, 32'h1111_2222, 32'h0, 0, 1'b0);

        do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b0);
        chk("mult_neg2x3", {1'b0, hi, lo}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        chk("multu_max", {1'b0, hi, lo}, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
        chk("div_neg7by2", {1'b0, hi, lo}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(3'd3, 32'h1234_5678, 32'h0, 0, 1'b0);
        chk("divu_zero", {div_zero, hi, lo}, {1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
        do_op(3'd5, 32'h0BAD_F00D, 32'h0, 0, 1'b0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        chk("div_overflow", {div_zero, hi, lo}, {1'b0, 32'h0, 32'h8000_0000});

        // Flush mid-calculation, then flush while done is high
        do_op(3'd4, 32'hAAAA_5555, 32'h0, 0, 1'b0);
        do_op(3'd0, $urandom, $urandom, 10, 1'b0);
        chk("hi_after_flush", {33'b0, hi}, {33'b0, 32'hAAAA_5555});
        do_op(3'd1, $urandom, $urandom, 33, 1'b0);

        // Flush in IDLE discards a simultaneous start
        start = 1'b1; op = 3'd4; inA = 32'h5A5A_5A5A; flush = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 3'd0; inA = $urandom; inB = $urandom;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush", {div_zero, hi, lo}, {m_dz, m_hi, m_lo});
        chk("idle_flush_busy", {64'b0, busy}, 65'd0);

        // Asynchronous reset in the middle of a multiply
        start = 1'b1; op = 3'd0; inA = $urandom; inB = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {30'b0, busy, done, div_zero, hi, lo}, 65'd0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd4, 32'hC0DE_0001, 32'h0, 0, 1'b0);

        // Randomized mix, occasional flush
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 33)) : 0;
            do_op(ro, pick(), pick(), fa, 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 65'(exp_q.size()), 65'd0);
        chk("done_count", 65'(done_seen), 65'(pushed));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL declare parameter WORD_WIDTH, default `WORD_WIDTH (32), giving the operand, HI and LO width.
REQ-002 The block SHALL declare parameter CNT_WIDTH, default 6, giving the iteration counter width; it SHALL satisfy 2^CNT_WIDTH > WORD_WIDTH.
REQ-003 The block SHALL have a single clock and an asynchronous active-low reset, as the next two port lines state.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new operation; sampled on clk only when the block is idle.
REQ-007 op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-op.
REQ-008 inA  input  WORD_WIDTH  multiplicand, dividend, or MTHI/MTLO data.
REQ-009 inB  input  WORD_WIDTH  multiplier or divisor.
REQ-010 flush  input  1  abort the in-flight operation.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 done  output  1  one-cycle pulse when HI and LO hold a new result.
REQ-013 hi  output  WORD_WIDTH  current HI register.
REQ-014 lo  output  WORD_WIDTH  current LO register.
REQ-015 div_zero  output  1  sticky flag set by a DIV or DIVU with inB equal to 0; cleared by the next accepted start.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE; busy SHALL be high exactly when the state is CALC or DONE.
REQ-017 In IDLE with start=1, op MULT/MULTU/DIV/DIVU: latch inA, inB and op; clear the counter; go to CALC.
REQ-018 In IDLE with start=1, op MTHI or MTLO: write inA to hi or lo at that edge; stay in IDLE; done SHALL NOT pulse.
REQ-019 In IDLE with start=1 and op 110 or 111: no state change.
REQ-020 start SHALL be ignored while busy=1; latched operands SHALL be immune to inA, inB and op changes after acceptance.
REQ-021 CALC SHALL perform exactly one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-022 CALC SHALL advance to DONE on the edge that completes step WORD_WIDTH.
REQ-023 hi and lo SHALL be written on the edge entering DONE.
REQ-024 done SHALL be high for the single cycle spent in DONE; DONE SHALL always return to IDLE on the next edge.
REQ-025 Latency: start accepted at edge 0 gives done high after edge WORD_WIDTH and busy low after edge WORD_WIDTH+1; a new start is accepted no earlier than edge WORD_WIDTH+1.
REQ-026 MULT and MULTU SHALL produce a 2*WORD_WIDTH product, signed or unsigned respectively; {hi,lo} = product.
REQ-027 Signed multiply SHALL be performed as a magnitude product followed by sign correction.
REQ-028 DIV and DIVU SHALL set lo = quotient and hi = remainder.
REQ-029 Signed division SHALL truncate the quotient toward zero; the remainder sign SHALL follow the dividend.
REQ-030 Division by zero SHALL set lo = all ones and hi = dividend, set div_zero, and still take the full WORD_WIDTH+1 cycles.
REQ-031 Signed overflow (most-negative / -1) SHALL set lo = most-negative and hi = 0 without flagging.
REQ-032 flush=1 in CALC or DONE SHALL force IDLE at the next edge, leave hi and lo unchanged, and suppress done; if done is already high in that cycle, hi and lo keep the written result.
REQ-033 flush=1 in IDLE SHALL discard a simultaneous start, including MTHI and MTLO.
REQ-034 hi and lo SHALL be registered outputs and SHALL change only per REQ-018, REQ-023 and REQ-032.

Reset
REQ-035 rst_n=0 SHALL immediately, independent of clk, force IDLE, counter=0, hi=0, lo=0, busy=0, done=0 and div_zero=0, including mid-operation.
REQ-036 Following rst_n deassertion, the first start SHALL be accepted on the next rising edge with no extra wait cycles.

Verification
REQ-037 MULT inA=0xFFFFFFFE (-2), inB=0x00000003 -> done after 32 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 MULTU inA=0xFFFFFFFF, inB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-039 DIV inA=0xFFFFFFF9 (-7), inB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-040 DIVU inA=0x12345678, inB=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1; next MTLO start clears div_zero.
REQ-041 DIV inA=0x80000000, inB=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; start pulsed at cycles 5 and 20 is ignored.
REQ-042 MTHI 0xAAAA5555, then MULT flushed at cycle 10 -> hi stays 0xAAAA5555, no done; rst_n low at cycle 15 of a second MULT -> all outputs 0 immediately.
